// File: rtl/mac_row_drain.sv
// Result reader for a row of N MAC units: snapshots every accumulator on start,
// then streams the snapshot out one PE per beat over valid/ready with index and last tags.
module mac_row_drain #(
  parameter int N     = 4,
  parameter int ACC_W = 32,
  parameter int IDX_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N*ACC_W-1:0] acc_in,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_data,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t           state;
  logic [ACC_W-1:0] snap [N];
  logic [IDX_W-1:0] next_idx;

  assign next_idx = out_idx + IDX_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      // NOTE: the snapshot buffer is small and must read as zero after reset, so it
      // is built from resettable flops rather than an unreset RAM.
      for (int k = 0; k < N; k++) snap[k] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < N; k++) snap[k] <= acc_in[k*ACC_W +: ACC_W];
            // Beat 0 comes straight from acc_in so it is presented the cycle after start.
            out_data  <= acc_in[ACC_W-1:0];
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          // out_valid is always high here, so out_ready alone marks a handshake.
          if (out_ready) begin
            if (out_idx == LAST_IDX) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              out_idx  <= next_idx;
              out_data <= snap[next_idx];
              out_last <= (next_idx == LAST_IDX);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_row_drain.sv
// Bench for mac_row_drain: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the expected beat stream.
module tb_mac_row_drain;

  localparam int N     = 4;
  localparam int ACC_W = 32;
  localparam int IDX_W = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [N*ACC_W-1:0] acc_in;
  logic               busy;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_data;
  logic [IDX_W-1:0]   out_idx;
  logic               out_last;
  logic               done;

  mac_row_drain #(.N(N), .ACC_W(ACC_W), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .acc_in    (acc_in),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: words still owed downstream (front = current beat), index of the front
  // word, and whether this cycle should show the done pulse.
  logic [ACC_W-1:0] mq[$];
  int               m_idx  = 0;
  bit               m_done = 1'b0;

  // Observed activity, counted straight from DUT outputs.
  int beats = 0;
  int dones = 0;
  int cyc   = 0;
  int beat_cyc[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs, advance model.
  task automatic step(input logic st, input logic rdy, input logic [N*ACC_W-1:0] acc);
    bit exp_valid, exp_busy, nd;
    start = st; out_ready = rdy; acc_in = acc;
    #1;
    exp_valid = (mq.size() > 0);
    exp_busy  = exp_valid || m_done;
    check("out_valid", 64'(out_valid), 64'(exp_valid));
    check("busy", 64'(busy), 64'(exp_busy));
    check("done", 64'(done), 64'(m_done));
    if (exp_valid) begin
      check("out_data", 64'(out_data), 64'(mq[0]));
      check("out_idx", 64'(out_idx), 64'(m_idx));
      check("out_last", 64'(out_last), 64'(mq.size() == 1));
    end else begin
      check("out_last_idle", 64'(out_last), 64'd0);
    end
    if (out_valid && rdy) begin
      beats++;
      beat_cyc.push_back(cyc);
    end
    if (done) dones++;
    nd = 1'b0;
    if (exp_valid && rdy) begin
      void'(mq.pop_front());
      m_idx++;
      if (mq.size() == 0) nd = 1'b1;
    end
    if (!exp_busy && st) begin
      for (int k = 0; k < N; k++) mq.push_back(acc[k*ACC_W +: ACC_W]);
      m_idx = 0;
    end
    m_done = nd;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_data"}, 64'(out_data), 64'd0);
    check({tag, "_idx"}, 64'(out_idx), 64'd0);
    check({tag, "_last"}, 64'(out_last), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
  endtask

  task automatic clear_counts();
    beats = 0;
    dones = 0;
    beat_cyc.delete();
  endtask

  logic [N*ACC_W-1:0] seq_a, seq_b, seq_c, seq_d, fill;

  initial begin
    seq_a = {32'h0000_0004, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001};
    seq_b = {32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    seq_c = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
    seq_d = {32'h0000_000D, 32'h0000_000C, 32'h0000_000B, 32'h0000_000A};
    fill  = {N{32'h1234_5678}};

    reset = 1'b1; start = 1'b0; out_ready = 1'b0; acc_in = '0;
    #1;
    check_reset_values("reset");
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b1, seq_a);

    // Basic drain with ready held high: beats, done and idle on a fixed timeline.
    clear_counts();
    step(1'b1, 1'b1, seq_a);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, seq_a);
    check("basic_beats", 64'(beats), 64'd4);
    check("basic_dones", 64'(dones), 64'd1);
    check("basic_contiguous", 64'(beat_cyc[3] - beat_cyc[0]), 64'd3);

    // Backpressure pattern 0,0,1,0,1,1,0,1.
    clear_counts();
    step(1'b1, 1'b0, seq_a);
    begin
      logic [7:0] pat;
      pat = 8'b1011_0100;
      for (int i = 0; i < 8; i++) step(1'b0, pat[i], seq_a);
    end
    step(1'b0, 1'b0, seq_a);
    step(1'b0, 1'b0, seq_a);
    check("bp_beats", 64'(beats), 64'd4);
    check("bp_dones", 64'(dones), 64'd1);

    // Snapshot isolation: acc_in changes right after the accepting edge.
    clear_counts();
    step(1'b1, 1'b1, seq_b);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, fill);
    check("iso_beats", 64'(beats), 64'd4);

    // Start during SEND idx=1 and during DONE is ignored; first idle cycle restarts.
    clear_counts();
    step(1'b1, 1'b1, seq_a);
    step(1'b0, 1'b1, seq_c);
    step(1'b1, 1'b1, seq_c);
    step(1'b0, 1'b1, seq_c);
    step(1'b0, 1'b1, seq_c);
    step(1'b1, 1'b1, seq_c);
    check("busy_start_beats", 64'(beats), 64'd4);
    check("busy_start_dones", 64'(dones), 64'd1);
    step(1'b1, 1'b1, seq_c);
    check("restart_valid", 64'(out_valid), 64'd1);

    // Back-to-back: finish this drain, restart in its first idle cycle, measure the gap.
    clear_counts();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, seq_a);
    step(1'b0, 1'b1, seq_a);
    step(1'b1, 1'b1, seq_a);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, seq_a);
    check("b2b_beats", 64'(beats), 64'd8);
    check("b2b_gap", 64'(beat_cyc[4] - beat_cyc[3]), 64'd3);

    // Asynchronous reset between edges while beat idx=2 is on the bus.
    clear_counts();
    step(1'b1, 1'b1, seq_a);
    step(1'b0, 1'b1, seq_a);
    step(1'b0, 1'b1, seq_a);
    check("pre_reset_idx", 64'(out_idx), 64'd2);
    #2 reset = 1'b1;
    #1;
    check_reset_values("async_reset");
    mq.delete();
    m_done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_values("held_reset");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, seq_a);
    check("reset_no_done", 64'(dones), 64'd0);
    clear_counts();
    step(1'b1, 1'b1, seq_d);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, seq_a);
    check("post_reset_beats", 64'(beats), 64'd4);
    check("post_reset_dones", 64'(dones), 64'd1);

    // Random traffic: sparse starts, random ready, accumulators changing every cycle.
    for (int i = 0; i < 400; i++) begin
      logic [N*ACC_W-1:0] r;
      for (int k = 0; k < N; k++) r[k*ACC_W +: ACC_W] = $urandom;
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0), r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
